// File: rtl/keypad_scan_debounce_if.sv
// Keypad pin and key-event bundle between the matrix scanner and the entry logic.
// The slave side is the scanner; the master side is whoever drives the rows and consumes key events.
interface keypad_scan_debounce_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 8
);
  logic [ROWS-1:0]  fil;
  logic [COLS-1:0]  col;
  logic [3:0]       tecla;
  logic             tipo;
  logic             tecla_valid;
  logic             tecla_held;
  logic [CNT_W-1:0] pulsacion;

  modport master (
    output fil,
    input  col, tecla, tipo, tecla_valid, tecla_held, pulsacion
  );

  modport slave (
    input  fil,
    output col, tecla, tipo, tecla_valid, tecla_held, pulsacion
  );
endinterface

// File: rtl/keypad_scan_debounce.sv
// Column-scanning keypad reader: whole-sweep debounce, ghost rejection and one registered event per press.
// Row and column geometry, dwell time and debounce depth are parameters.
module keypad_scan_debounce #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 6,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  keypad_scan_debounce_if.slave kp
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DEB_W  = $clog2(DEB_SCANS + 1);

  // Index is row*4+col with row 0 on the fil MSB; FUNC_MASK marks the function keys.
  localparam logic [3:0] KEY_LUT [16] = '{
    4'd1,  4'd2, 4'd3, 4'd0,
    4'd4,  4'd5, 4'd6, 4'd1,
    4'd7,  4'd8, 4'd9, 4'd2,
    4'd10, 4'd0, 4'd6, 4'd3
  };
  localparam logic [15:0] FUNC_MASK = 16'b1101_1000_1000_1000;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  logic [ROWS-1:0]   fil_s1_q, fil_s1_d, fil_s2_q, fil_s2_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CIDX_W-1:0] cidx_q, cidx_d;
  logic [COLS-1:0]   col_q, col_d;
  logic              acc_any_q, acc_any_d, acc_multi_q, acc_multi_d;
  logic [RIDX_W-1:0] acc_row_q, acc_row_d;
  logic [CIDX_W-1:0] acc_col_q, acc_col_d;
  state_t            state_q, state_d;
  logic [RIDX_W-1:0] cand_row_q, cand_row_d;
  logic [CIDX_W-1:0] cand_col_q, cand_col_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        tecla_q, tecla_d;
  logic              tipo_q, tipo_d, valid_q, valid_d, held_q, held_d;
  logic [CNT_W-1:0]  puls_q, puls_d;

  logic              last_dwell, sweep_end, hit_any, hit_many;
  logic              m_any, m_multi, res_none, res_single, same_key, accept;
  logic [RIDX_W-1:0] hit_row, m_row;
  logic [CIDX_W-1:0] m_col;
  logic [4:0]        dec;

  function automatic logic [4:0] decode_key(input logic [RIDX_W-1:0] r,
                                            input logic [CIDX_W-1:0] c);
    int         lin;
    logic [3:0] t;
    logic       digit;
    lin   = int'(r) * COLS + int'(c);
    t     = lin[3:0];
    digit = 1'b1;
    if (ROWS == 4 && COLS == 4) begin
      t     = KEY_LUT[lin[3:0]];
      digit = ~FUNC_MASK[lin[3:0]];
    end
    return {digit, t};
  endfunction

  always_comb begin
    fil_s1_d   = kp.fil;
    fil_s2_d   = fil_s1_q;
    last_dwell = (div_q == DIV_W'(SCAN_DIV - 1));
    sweep_end  = last_dwell && (cidx_q == CIDX_W'(COLS - 1));
    div_d      = last_dwell ? '0 : div_q + DIV_W'(1);
    cidx_d     = cidx_q;
    col_d      = col_q;
    if (last_dwell) begin
      cidx_d = (cidx_q == CIDX_W'(COLS - 1)) ? '0 : cidx_q + CIDX_W'(1);
      col_d  = {col_q[0], col_q[COLS-1:1]};
    end

    // Classify this column's sample, then fold it into the running sweep summary.
    hit_any  = 1'b0;
    hit_many = 1'b0;
    hit_row  = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (fil_s2_q[i]) begin
        if (hit_any) hit_many = 1'b1;
        hit_any = 1'b1;
        hit_row = RIDX_W'(ROWS - 1 - i);
      end
    end
    m_any      = acc_any_q | hit_any;
    m_multi    = acc_multi_q | hit_many | (hit_any & acc_any_q);
    m_row      = hit_any ? hit_row : acc_row_q;
    m_col      = hit_any ? cidx_q : acc_col_q;
    res_none   = ~m_any;
    res_single = m_any & ~m_multi;
    same_key   = (m_row == cand_row_q) && (m_col == cand_col_q);
    dec        = decode_key(m_row, m_col);

    acc_any_d   = acc_any_q;
    acc_multi_d = acc_multi_q;
    acc_row_d   = acc_row_q;
    acc_col_d   = acc_col_q;
    if (last_dwell) begin
      acc_any_d   = sweep_end ? 1'b0 : m_any;
      acc_multi_d = sweep_end ? 1'b0 : m_multi;
      acc_row_d   = sweep_end ? '0 : m_row;
      acc_col_d   = sweep_end ? '0 : m_col;
    end

    state_d    = state_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    cnt_d      = cnt_q;
    tecla_d    = tecla_q;
    tipo_d     = tipo_q;
    valid_d    = 1'b0;
    held_d     = held_q;
    puls_d     = puls_q;
    accept     = 1'b0;

    // The FSM only moves on sweep boundaries; cnt_q serves as both debounce and release counter.
    if (sweep_end) begin
      unique case (state_q)
        IDLE: begin
          if (res_single) begin
            cand_row_d = m_row;
            cand_col_d = m_col;
            if (DEB_SCANS == 1) accept = 1'b1;
            else begin
              state_d = DEBOUNCE;
              cnt_d   = DEB_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (res_single && same_key) begin
            if (cnt_q == DEB_W'(DEB_SCANS - 1)) accept = 1'b1;
            else cnt_d = cnt_q + DEB_W'(1);
          end else if (res_single) begin
            cand_row_d = m_row;
            cand_col_d = m_col;
            cnt_d      = DEB_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (res_none) begin
            if (DEB_SCANS == 1) begin
              state_d = IDLE;
              held_d  = 1'b0;
            end else begin
              state_d = RELEASE;
              cnt_d   = DEB_W'(1);
            end
          end
        end
        RELEASE: begin
          if (!res_none) state_d = HELD;
          else if (cnt_q == DEB_W'(DEB_SCANS - 1)) begin
            state_d = IDLE;
            held_d  = 1'b0;
          end else cnt_d = cnt_q + DEB_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    if (accept) begin
      state_d = HELD;
      tecla_d = dec[3:0];
      tipo_d  = dec[4];
      valid_d = 1'b1;
      held_d  = 1'b1;
      puls_d  = puls_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fil_s1_q    <= '0;
      fil_s2_q    <= '0;
      div_q       <= '0;
      cidx_q      <= '0;
      col_q       <= {1'b1, {(COLS-1){1'b0}}};
      acc_any_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_row_q   <= '0;
      acc_col_q   <= '0;
      state_q     <= IDLE;
      cand_row_q  <= '0;
      cand_col_q  <= '0;
      cnt_q       <= '0;
      tecla_q     <= '0;
      tipo_q      <= 1'b0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
      puls_q      <= '0;
    end else begin
      fil_s1_q    <= fil_s1_d;
      fil_s2_q    <= fil_s2_d;
      div_q       <= div_d;
      cidx_q      <= cidx_d;
      col_q       <= col_d;
      acc_any_q   <= acc_any_d;
      acc_multi_q <= acc_multi_d;
      acc_row_q   <= acc_row_d;
      acc_col_q   <= acc_col_d;
      state_q     <= state_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      cnt_q       <= cnt_d;
      tecla_q     <= tecla_d;
      tipo_q      <= tipo_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
      puls_q      <= puls_d;
    end
  end

  assign kp.col         = col_q;
  assign kp.tecla       = tecla_q;
  assign kp.tipo        = tipo_q;
  assign kp.tecla_valid = valid_q;
  assign kp.tecla_held  = held_q;
  assign kp.pulsacion   = puls_q;

endmodule
